// File: rtl/kernel_pr_start_fanout_fifo_srl.sv
// Token storage for the fan-out start FIFO: a shift register with a
// selectable read tap; new tokens enter at index 0, the oldest sits at count-1.
module kernel_pr_start_fanout_fifo_srl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 6
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            sr_q[0] <= data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q = sr_q[a];

endmodule

// File: rtl/kernel_pr_start_fanout_fifo.sv
// Start-token FIFO that fans one producer out to NUM_RD consumers; an entry
// is popped only once every consumer has read it exactly once.
module kernel_pr_start_fanout_fifo #(
    parameter int unsigned DATA_WIDTH  = 1,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned DEPTH       = 6,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned AFULL_LEVEL = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic [NUM_RD-1:0]     if_read_ce,
    input  logic [NUM_RD-1:0]     if_read,
    output logic [NUM_RD-1:0]     if_empty_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [NUM_RD-1:0]   TAKEN_ALL = '1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C   = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_C     = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   count_q, count_d, head_idx;
    logic [NUM_RD-1:0]     taken_q, taken_d;
    logic [NUM_RD-1:0]     empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  afull_n_q, afull_n_d;
    logic                  wr_fire, pop;
    logic [NUM_RD-1:0]     rd_fire;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_fire = if_write & if_write_ce & full_n_q;
    assign rd_fire = if_read & if_read_ce & empty_n_q;
    // Pop in the same cycle as the last outstanding consumer's read.
    assign pop     = (count_q != '0) && ((taken_q | rd_fire) == TAKEN_ALL);

    assign head_idx = (count_q != '0) ? (count_q - ONE_C) : '0;
    assign rd_addr  = head_idx[ADDR_WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        case ({wr_fire, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        taken_d   = pop ? '0 : (taken_q | rd_fire);
        full_n_d  = (count_d != DEPTH_C);
        afull_n_d = (count_d < AFULL_C);
        empty_n_d = {NUM_RD{count_d != '0}} & ~taken_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            taken_q   <= '0;
            empty_n_q <= '0;
            full_n_q  <= 1'b1;
            afull_n_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            taken_q   <= taken_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_n_q <= afull_n_d;
        end
    end

    kernel_pr_start_fanout_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .data (if_din),
        .ce   (wr_fire),
        .a    (rd_addr),
        .q    (if_dout)
    );

    assign count            = count_q;
    assign if_empty_n       = empty_n_q;
    assign if_full_n        = full_n_q;
    assign if_almost_full_n = afull_n_q;

endmodule

// File: tb/tb_kernel_pr_start_fanout_fifo.sv
// Directed bench for the fan-out start FIFO with default parameters
// (1-bit tokens, depth 6, two consumers, almost-full at 5).
module tb_kernel_pr_start_fanout_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       if_write_ce, if_write;
    logic [0:0] if_din;
    logic       if_full_n, if_almost_full_n;
    logic [1:0] if_read_ce, if_read, if_empty_n;
    logic [0:0] if_dout;
    logic [3:0] count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    kernel_pr_start_fanout_fifo #(
        .DATA_WIDTH  (1),
        .ADDR_WIDTH  (3),
        .DEPTH       (6),
        .NUM_RD      (2),
        .AFULL_LEVEL (5)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_write_ce      (if_write_ce),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_full_n        (if_full_n),
        .if_almost_full_n (if_almost_full_n),
        .if_read_ce       (if_read_ce),
        .if_read          (if_read),
        .if_empty_n       (if_empty_n),
        .if_dout          (if_dout),
        .count            (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Set inputs for the next edge, advance one cycle, land 1 time unit after it.
    task automatic step(input logic w, input logic d, input logic [1:0] rd);
        if_write = w;
        if_din   = d;
        if_read  = rd;
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 2'b00;
    endtask

    task automatic flags(input string tag, input logic [3:0] c, input logic [1:0] e,
                         input logic f, input logic af);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".empty_n"}, 32'(if_empty_n), 32'(e));
        check({tag, ".full_n"}, 32'(if_full_n), 32'(f));
        check({tag, ".afull_n"}, 32'(if_almost_full_n), 32'(af));
    endtask

    logic [5:0] fill_tok;

    initial begin
        reset_n     = 1'b0;
        if_write_ce = 1'b1;
        if_write    = 1'b0;
        if_din      = '0;
        if_read_ce  = 2'b11;
        if_read     = 2'b00;

        // Reset
        #12;
        flags("rst_hold", 4'd0, 2'b00, 1'b1, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        flags("rst_rel", 4'd0, 2'b00, 1'b1, 1'b1);

        // Read while empty is ignored
        step(1'b0, 1'b0, 2'b11);
        flags("empty_rd", 4'd0, 2'b00, 1'b1, 1'b1);

        // Write with clock-enable low is dropped
        if_write_ce = 1'b0;
        step(1'b1, 1'b1, 2'b00);
        check("wce_low.count", 32'(count), 32'd0);
        if_write_ce = 1'b1;

        // Fan-out with read skew
        step(1'b1, 1'b1, 2'b00);
        flags("fan_wr", 4'd1, 2'b11, 1'b1, 1'b1);
        check("fan_wr.dout", 32'(if_dout), 32'd1);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b01);
        flags("fan_rd0", 4'd1, 2'b10, 1'b1, 1'b1);
        step(1'b0, 1'b0, 2'b01);
        flags("fan_rd0_again", 4'd1, 2'b10, 1'b1, 1'b1);
        step(1'b0, 1'b0, 2'b10);
        flags("fan_rd1", 4'd0, 2'b00, 1'b1, 1'b1);

        // Fill to full; tokens oldest-first 1,0,1,1,0,0
        fill_tok = 6'b001101;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, fill_tok[i], 2'b00);
            check("fill.count", 32'(count), 32'(i + 1));
            check("fill.afull_n", 32'(if_almost_full_n), (i >= 4) ? 32'd0 : 32'd1);
            check("fill.full_n", 32'(if_full_n), (i == 5) ? 32'd0 : 32'd1);
        end
        check("fill.dout", 32'(if_dout), 32'd1);
        step(1'b1, 1'b1, 2'b00);
        flags("fill_drop", 4'd6, 2'b11, 1'b0, 1'b0);
        check("fill_drop.dout", 32'(if_dout), 32'd1);

        // Full plus pop: pop happens, write dropped
        step(1'b1, 1'b1, 2'b11);
        flags("full_pop", 4'd5, 2'b11, 1'b1, 1'b0);
        check("full_pop.dout", 32'(if_dout), 32'd0);

        // Drain remaining tokens 0,1,1,0,0 in order
        for (int i = 1; i < 6; i++) begin
            check("drain.dout", 32'(if_dout), 32'(fill_tok[i]));
            step(1'b0, 1'b0, 2'b11);
            check("drain.count", 32'(count), 32'(5 - i));
        end
        flags("drained", 4'd0, 2'b00, 1'b1, 1'b1);

        // Simultaneous write and pop at count=1
        step(1'b1, 1'b1, 2'b00);
        check("sim_pre.dout", 32'(if_dout), 32'd1);
        step(1'b1, 1'b0, 2'b11);
        flags("sim", 4'd1, 2'b11, 1'b1, 1'b1);
        check("sim.dout", 32'(if_dout), 32'd0);
        step(1'b0, 1'b0, 2'b11);
        flags("sim_clr", 4'd0, 2'b00, 1'b1, 1'b1);

        // Order 1,0,1 with consumer skew
        step(1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, 2'b00);
        flags("ord_fill", 4'd3, 2'b11, 1'b1, 1'b1);
        check("ord0.dout", 32'(if_dout), 32'd1);
        step(1'b0, 1'b0, 2'b01);
        check("ord0_c0.empty_n", 32'(if_empty_n), 32'b10);
        check("ord0_c1.dout", 32'(if_dout), 32'd1);
        step(1'b0, 1'b0, 2'b10);
        flags("ord1", 4'd2, 2'b11, 1'b1, 1'b1);
        check("ord1_c1.dout", 32'(if_dout), 32'd0);
        step(1'b0, 1'b0, 2'b10);
        check("ord1_c1.empty_n", 32'(if_empty_n), 32'b01);
        check("ord1_c0.dout", 32'(if_dout), 32'd0);
        step(1'b0, 1'b0, 2'b01);
        flags("ord2", 4'd1, 2'b11, 1'b1, 1'b1);
        check("ord2.dout", 32'(if_dout), 32'd1);
        step(1'b0, 1'b0, 2'b11);
        flags("ord_done", 4'd0, 2'b00, 1'b1, 1'b1);

        // Asynchronous reset mid-run discards partial state
        step(1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b01);
        flags("pre_rst", 4'd2, 2'b10, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        flags("mid_rst", 4'd0, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        flags("post_rst", 4'd0, 2'b00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'b00);
        flags("post_rst_wr", 4'd1, 2'b11, 1'b1, 1'b1);
        check("post_rst_wr.dout", 32'(if_dout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
